multi_lock_manager: RTL and testbench
=====================================

// Module: multi_lock_manager
// PURPOSE
//  Multi-lock arbiter for accelerator critical sections: serves NUM_LOCKS independent locks over one
//  AXI-Stream request/ack pair, replacing the single-lock service on the manager's lock_in/lock_out
//  interfaces. Adds a wait-queue mode: a busy lock parks the requester and hands the lock over on
//  release (round-robin among waiters) instead of returning a busy-NACK.
// PARAMETERS
//  MAX_ACCS   16  number of accelerators (requester/destination IDs)
//  ACC_BITS   $clog2(MAX_ACCS)  width of tid/tdest
//  NUM_LOCKS  8   number of locks (>=1); LOCK_BITS = max(1,$clog2(NUM_LOCKS))
//  WAIT_MODE  0   0 = NACK when busy; 1 = queue waiter, grant on unlock
// PORTS
//  clk          in   1         clock
//  rst          in   1         synchronous reset, active-high
//  in_tvalid    in   1         request valid
//  in_tready    out  1         request ready
//  in_tid       in   ACC_BITS  requesting accelerator
//  in_tdata     in   64        [7:0] cmd (0x04 LOCK, 0x06 UNLOCK); [8+:LOCK_BITS] lock id
//  out_tvalid   out  1         ack valid
//  out_tready   in   1         ack ready
//  out_tdest    out  ACC_BITS  accelerator receiving ack
//  out_tdata    out  64        [7:0]=0x05; [8]=1 granted/0 busy; [16+:LOCK_BITS] lock id; rest 0
//  out_tlast    out  1         constant 1 (single-beat ack)
//  locks_busy   out  NUM_LOCKS bit i = lock i owned
//  err          out  1         1-cycle pulse on protocol error
// BEHAVIOUR
//  Reset (rst=1 at posedge): state IDLE, all owners cleared, waiter bitmaps 0, rr pointers 0;
//   out_tvalid=0, out_tdata=0, out_tdest=0, in_tready=0, locks_busy=0, err=0. Reset mid-ack drops it.
//  State per lock: busy bit, owner[ACC_BITS], waiters[MAX_ACCS] (WAIT_MODE=1 only).
//  FSM: IDLE -> (accept) EXEC -> SEND | IDLE; SEND -> IDLE when out_tvalid&&out_tready.
//  IDLE: in_tready=1; beat accepted on in_tvalid&&in_tready at cycle T; cmd/id/tid registered.
//  EXEC (T+1, in_tready=0), id = lock id, r = requester:
//   - id>=NUM_LOCKS or cmd not 0x04/0x06: err pulse, no state change, -> IDLE.
//   - LOCK, free: busy=1, owner=r, ack granted to r. LOCK by current owner: ack granted (idempotent).
//   - LOCK, busy, WAIT_MODE=0: ack busy([8]=0) to r, no state change.
//   - LOCK, busy, WAIT_MODE=1: set waiters[r], no ack (already set: no-op), -> IDLE.
//   - UNLOCK by non-owner or of free lock: err pulse, no state change, -> IDLE; never acked.
//   - UNLOCK by owner, no waiters (or WAIT_MODE=0): busy=0, -> IDLE, no ack.
//   - UNLOCK by owner, waiters!=0: pick first set bit scanning from (owner+1) mod MAX_ACCS upward
//     with wrap; owner=winner, clear its waiter bit, busy stays 1, ack granted to winner.
//  SEND: out_tvalid=1 from T+2; tdata/tdest stable until handshake; one request in flight max.
//  Ack latency with out_tready=1: accept at T, out_tvalid high at T+2, IDLE at T+3 (3-cycle issue).
//  locks_busy updated at end of EXEC (visible T+2). Backpressure on out holds FSM in SEND.
// TESTING
//  1. Reset, acc 3 LOCK id 2 -> ack tdest=3 tdata=0x0000_0000_0002_0105; locks_busy=0x04.
//  2. WAIT_MODE=0: acc 3 owns id 2, acc 5 LOCK id 2 -> ack tdest=5 tdata[8]=0; owner still 3.
//  3. WAIT_MODE=1: acc 3 owns id 0; accs 1,7,4 LOCK id 0 (no acks); acc 3 UNLOCK -> grant to 4,
//     4 UNLOCK -> grant 7, 7 UNLOCK -> grant 1 (wrap), 1 UNLOCK -> locks_busy[0]=0, no ack.
//  4. acc 2 UNLOCK id 1 owned by 6 -> err pulse 1 cycle, no ack; cmd 0x09 and id=NUM_LOCKS -> err.
//  5. out_tready=0 for 10 cycles during ack -> tdata/tdest stable, in_tready=0; then 1 handshake.
//  6. rst pulse while in SEND -> out_tvalid=0 next cycle, locks_busy=0, fresh LOCK granted.

Source files
------------

// File: rtl/multi_lock_manager.sv
// Multi-lock arbiter: serves NUM_LOCKS locks over one request/ack stream pair,
// answering busy with a NACK (WAIT_MODE=0) or parking waiters for round-robin hand-over (WAIT_MODE=1).
module multi_lock_manager #(
  parameter int unsigned MAX_ACCS  = 16,
  parameter int unsigned ACC_BITS  = $clog2(MAX_ACCS),
  parameter int unsigned NUM_LOCKS = 8,
  parameter int unsigned WAIT_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_tvalid,
  output logic                 in_tready,
  input  logic [ACC_BITS-1:0]  in_tid,
  input  logic [63:0]          in_tdata,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic [ACC_BITS-1:0]  out_tdest,
  output logic [63:0]          out_tdata,
  output logic                 out_tlast,
  output logic [NUM_LOCKS-1:0] locks_busy,
  output logic                 err
);

  localparam int unsigned LOCK_BITS = (NUM_LOCKS > 1) ? $clog2(NUM_LOCKS) : 1;
  localparam logic [7:0]  CMD_LOCK   = 8'h04;
  localparam logic [7:0]  CMD_UNLOCK = 8'h06;
  localparam logic [7:0]  CMD_ACK    = 8'h05;

  typedef enum logic [1:0] {IDLE, EXEC, SEND} state_t;

  state_t               state;
  logic [7:0]           cmd_q;
  logic [LOCK_BITS-1:0] id_q;
  logic [ACC_BITS-1:0]  tid_q;
  logic [ACC_BITS-1:0]  owner   [NUM_LOCKS];
  logic [MAX_ACCS-1:0]  waiters [NUM_LOCKS];

  logic                 id_ok;
  logic                 cmd_ok;
  logic [LOCK_BITS-1:0] sel;
  logic                 cur_busy;
  logic [ACC_BITS-1:0]  cur_owner;
  logic [MAX_ACCS-1:0]  cur_wait;
  logic                 is_owner;
  logic                 win_found;
  logic [ACC_BITS-1:0]  win;
  logic                 unused_tdata;

  assign out_tlast    = 1'b1;
  assign unused_tdata = ^{in_tdata[63:8+LOCK_BITS]};

  // Decode of the latched request against the addressed lock
  assign id_ok     = (32'(id_q) < NUM_LOCKS);
  assign cmd_ok    = (cmd_q == CMD_LOCK) || (cmd_q == CMD_UNLOCK);
  assign sel       = id_ok ? id_q : '0;
  assign cur_busy  = locks_busy[sel];
  assign cur_owner = owner[sel];
  assign cur_wait  = waiters[sel];
  assign is_owner  = cur_busy && (cur_owner == tid_q);

  // Next owner on hand-over: first waiter after the current owner, wrapping
  always_comb begin
    win_found = 1'b0;
    win       = '0;
    for (int unsigned k = 1; k <= MAX_ACCS; k++) begin
      if (!win_found && cur_wait[ACC_BITS'((32'(cur_owner) + k) % MAX_ACCS)]) begin
        win_found = 1'b1;
        win       = ACC_BITS'((32'(cur_owner) + k) % MAX_ACCS);
      end
    end
  end

  function automatic logic [63:0] ack_word(input logic granted);
    logic [63:0] w;
    w                   = '0;
    w[7:0]              = CMD_ACK;
    w[8]                = granted;
    w[16 +: LOCK_BITS]  = id_q;
    return w;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cmd_q      <= '0;
      id_q       <= '0;
      tid_q      <= '0;
      in_tready  <= 1'b0;
      out_tvalid <= 1'b0;
      out_tdest  <= '0;
      out_tdata  <= '0;
      locks_busy <= '0;
      err        <= 1'b0;
      for (int unsigned i = 0; i < NUM_LOCKS; i++) begin
        owner[i]   <= '0;
        waiters[i] <= '0;
      end
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          in_tready <= 1'b1;
          if (in_tvalid && in_tready) begin
            cmd_q     <= in_tdata[7:0];
            id_q      <= in_tdata[8 +: LOCK_BITS];
            tid_q     <= in_tid;
            in_tready <= 1'b0;
            state     <= EXEC;
          end
        end

        EXEC: begin
          state     <= IDLE;
          in_tready <= 1'b1;
          if (!id_ok || !cmd_ok) begin
            err <= 1'b1;
          end else if (cmd_q == CMD_LOCK) begin
            if (!cur_busy || is_owner) begin
              locks_busy[sel] <= 1'b1;
              owner[sel]      <= tid_q;
              out_tdest       <= tid_q;
              out_tdata       <= ack_word(1'b1);
              out_tvalid      <= 1'b1;
              in_tready       <= 1'b0;
              state           <= SEND;
            end else if (WAIT_MODE == 0) begin
              out_tdest  <= tid_q;
              out_tdata  <= ack_word(1'b0);
              out_tvalid <= 1'b1;
              in_tready  <= 1'b0;
              state      <= SEND;
            end else begin
              waiters[sel][tid_q] <= 1'b1;
            end
          end else if (!is_owner) begin
            err <= 1'b1;
          end else if (WAIT_MODE != 0 && win_found) begin
            // Hand the lock straight to the next waiter; it stays busy
            owner[sel]        <= win;
            waiters[sel][win] <= 1'b0;
            out_tdest         <= win;
            out_tdata         <= ack_word(1'b1);
            out_tvalid        <= 1'b1;
            in_tready         <= 1'b0;
            state             <= SEND;
          end else begin
            locks_busy[sel] <= 1'b0;
          end
        end

        SEND: begin
          if (out_tready) begin
            out_tvalid <= 1'b0;
            in_tready  <= 1'b1;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_lock_manager.sv
// Bench for multi_lock_manager: one NACK-mode and one wait-queue-mode instance, table vectors
// plus hand sequences, acks checked through per-instance expected-ack queues.
module tb_multi_lock_manager;

  localparam int unsigned NL = 6;

  typedef struct {
    logic [3:0]  dest;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    int          d;
    logic [3:0]  tid;
    logic [7:0]  cmd;
    logic [7:0]  id;
    bit          ack;
    logic [3:0]  dest;
    bit          gnt;
    bit          e;
    logic [NL-1:0] busy;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_tvalid  [2];
  logic          in_tready  [2];
  logic [3:0]    in_tid     [2];
  logic [63:0]   in_tdata   [2];
  logic          out_tvalid [2];
  logic          out_tready [2];
  logic [3:0]    out_tdest  [2];
  logic [63:0]   out_tdata  [2];
  logic          out_tlast  [2];
  logic [NL-1:0] locks_busy [2];
  logic          err        [2];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   err_cnt  [2];
  exp_t q0[$];
  exp_t q1[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  multi_lock_manager #(.MAX_ACCS(16), .NUM_LOCKS(NL), .WAIT_MODE(0)) dut0 (
    .clk(clk), .rst(rst),
    .in_tvalid(in_tvalid[0]), .in_tready(in_tready[0]), .in_tid(in_tid[0]), .in_tdata(in_tdata[0]),
    .out_tvalid(out_tvalid[0]), .out_tready(out_tready[0]), .out_tdest(out_tdest[0]),
    .out_tdata(out_tdata[0]), .out_tlast(out_tlast[0]), .locks_busy(locks_busy[0]), .err(err[0])
  );

  multi_lock_manager #(.MAX_ACCS(16), .NUM_LOCKS(NL), .WAIT_MODE(1)) dut1 (
    .clk(clk), .rst(rst),
    .in_tvalid(in_tvalid[1]), .in_tready(in_tready[1]), .in_tid(in_tid[1]), .in_tdata(in_tdata[1]),
    .out_tvalid(out_tvalid[1]), .out_tready(out_tready[1]), .out_tdest(out_tdest[1]),
    .out_tdata(out_tdata[1]), .out_tlast(out_tlast[1]), .locks_busy(locks_busy[1]), .err(err[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ack_data(input logic [7:0] id, input bit gnt);
    return 64'h05 | (64'(gnt) << 8) | (64'(id) << 16);
  endfunction

  task automatic push_exp(input int d, input logic [3:0] dest, input logic [63:0] data);
    exp_t e;
    e.dest = dest;
    e.data = data;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  // Ack scoreboard and err pulse counter; a handshake seen here completes on the next posedge
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst && out_tvalid[d] && out_tready[d]) begin
        if (qsize(d) == 0) begin
          chk($sformatf("unexpected_ack%0d", d), 64'(out_tdest[d]), 64'hffff);
        end else begin
          exp_t e;
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("ack_tdest%0d", d), 64'(out_tdest[d]), 64'(e.dest));
          chk($sformatf("ack_tdata%0d", d), out_tdata[d], e.data);
          chk($sformatf("ack_tlast%0d", d), 64'(out_tlast[d]), 64'h1);
        end
      end
      if (!rst && err[d]) err_cnt[d]++;
    end
  end

  task automatic issue(input int d, input logic [3:0] tid, input logic [7:0] cmd, input logic [7:0] id);
    int n = 0;
    @(negedge clk);
    while (!in_tready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_tready[d]) chk("issue_ready_timeout", 64'(in_tready[d]), 64'h1);
    in_tvalid[d] = 1'b1;
    in_tid[d]    = tid;
    in_tdata[d]  = {48'h0, id, cmd};
    @(posedge clk);
    #1;
    in_tvalid[d] = 1'b0;
    in_tdata[d]  = '0;
  endtask

  task automatic wait_idle(input int d);
    int n = 0;
    @(negedge clk);
    while (!(in_tready[d] && !out_tvalid[d]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!(in_tready[d] && !out_tvalid[d]))
      chk("idle_timeout", 64'({in_tready[d], out_tvalid[d]}), 64'h2);
  endtask

  task automatic run_vec(input int k, input vec_t v);
    int e0;
    e0 = err_cnt[v.d];
    if (v.ack) push_exp(v.d, v.dest, ack_data(v.id, v.gnt));
    issue(v.d, v.tid, v.cmd, v.id);
    wait_idle(v.d);
    @(negedge clk);
    chk($sformatf("v%0d_err", k), 64'(err_cnt[v.d] - e0), 64'(v.e));
    chk($sformatf("v%0d_busy", k), 64'(locks_busy[v.d]), 64'(v.busy));
    chk($sformatf("v%0d_ackq", k), 64'(qsize(v.d)), 64'h0);
  endtask

  initial begin
    logic [63:0] hold_data;
    logic [3:0]  hold_dest;

    // d, tid, cmd, id, ack, dest, gnt, err, busy
    vecs.push_back('{0, 4'd3, 8'h04, 8'd2, 1'b1, 4'd3, 1'b1, 1'b0, 6'h04});
    vecs.push_back('{0, 4'd5, 8'h04, 8'd2, 1'b1, 4'd5, 1'b0, 1'b0, 6'h04});
    vecs.push_back('{0, 4'd3, 8'h04, 8'd2, 1'b1, 4'd3, 1'b1, 1'b0, 6'h04});
    vecs.push_back('{0, 4'd5, 8'h06, 8'd2, 1'b0, 4'd0, 1'b0, 1'b1, 6'h04});
    vecs.push_back('{0, 4'd6, 8'h04, 8'd1, 1'b1, 4'd6, 1'b1, 1'b0, 6'h06});
    vecs.push_back('{0, 4'd2, 8'h06, 8'd1, 1'b0, 4'd0, 1'b0, 1'b1, 6'h06});
    vecs.push_back('{0, 4'd2, 8'h09, 8'd1, 1'b0, 4'd0, 1'b0, 1'b1, 6'h06});
    vecs.push_back('{0, 4'd2, 8'h04, 8'd6, 1'b0, 4'd0, 1'b0, 1'b1, 6'h06});
    vecs.push_back('{0, 4'd2, 8'h06, 8'd0, 1'b0, 4'd0, 1'b0, 1'b1, 6'h06});
    vecs.push_back('{0, 4'd3, 8'h06, 8'd2, 1'b0, 4'd0, 1'b0, 1'b0, 6'h02});
    vecs.push_back('{0, 4'd5, 8'h04, 8'd2, 1'b1, 4'd5, 1'b1, 1'b0, 6'h06});
    vecs.push_back('{1, 4'd3, 8'h04, 8'd0, 1'b1, 4'd3, 1'b1, 1'b0, 6'h01});
    vecs.push_back('{1, 4'd1, 8'h04, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0, 6'h01});
    vecs.push_back('{1, 4'd7, 8'h04, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0, 6'h01});
    vecs.push_back('{1, 4'd4, 8'h04, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0, 6'h01});
    vecs.push_back('{1, 4'd4, 8'h04, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0, 6'h01});
    vecs.push_back('{1, 4'd3, 8'h06, 8'd0, 1'b1, 4'd4, 1'b1, 1'b0, 6'h01});
    vecs.push_back('{1, 4'd4, 8'h06, 8'd0, 1'b1, 4'd7, 1'b1, 1'b0, 6'h01});
    vecs.push_back('{1, 4'd7, 8'h06, 8'd0, 1'b1, 4'd1, 1'b1, 1'b0, 6'h01});
    vecs.push_back('{1, 4'd1, 8'h06, 8'd0, 1'b0, 4'd0, 1'b0, 1'b0, 6'h00});
    vecs.push_back('{1, 4'd9, 8'h06, 8'd5, 1'b0, 4'd0, 1'b0, 1'b1, 6'h00});
    vecs.push_back('{1, 4'd15, 8'h04, 8'd5, 1'b1, 4'd15, 1'b1, 1'b0, 6'h20});

    for (int d = 0; d < 2; d++) begin
      in_tvalid[d]  = 1'b0;
      in_tid[d]     = '0;
      in_tdata[d]   = '0;
      out_tready[d] = 1'b1;
      err_cnt[d]    = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_tvalid%0d", d), 64'(out_tvalid[d]), 64'h0);
      chk($sformatf("rst_tready%0d", d), 64'(in_tready[d]), 64'h0);
      chk($sformatf("rst_tdata%0d", d), out_tdata[d], 64'h0);
      chk($sformatf("rst_tdest%0d", d), 64'(out_tdest[d]), 64'h0);
      chk($sformatf("rst_busy%0d", d), 64'(locks_busy[d]), 64'h0);
      chk($sformatf("rst_err%0d", d), 64'(err[d]), 64'h0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < vecs.size(); k++) run_vec(k, vecs[k]);

    // Issue latency with ack taken immediately (lock 1 re-locked by its owner)
    push_exp(0, 4'd6, ack_data(8'd1, 1'b1));
    issue(0, 4'd6, 8'h04, 8'd1);
    chk("lat_ready_t0", 64'(in_tready[0]), 64'h0);
    @(negedge clk);
    chk("lat_valid_t1", 64'(out_tvalid[0]), 64'h0);
    @(negedge clk);
    chk("lat_valid_t2", 64'(out_tvalid[0]), 64'h1);
    @(negedge clk);
    chk("lat_idle_t3", 64'({in_tready[0], out_tvalid[0]}), 64'h2);

    // Backpressure: ack held stable for 10 cycles, then exactly one handshake
    @(posedge clk);
    #1 out_tready[0] = 1'b0;
    push_exp(0, 4'd6, ack_data(8'd3, 1'b1));
    issue(0, 4'd6, 8'h04, 8'd3);
    @(negedge clk);
    @(negedge clk);
    chk("bp_valid", 64'(out_tvalid[0]), 64'h1);
    chk("bp_busy", 64'(locks_busy[0]), 64'h0e);
    hold_data = out_tdata[0];
    hold_dest = out_tdest[0];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", c),
          {out_tdata[0][61:0], out_tvalid[0], in_tready[0]}, {hold_data[61:0], 1'b1, 1'b0});
      chk($sformatf("bp_dest%0d", c), 64'(out_tdest[0]), 64'(hold_dest));
    end
    @(posedge clk);
    #1 out_tready[0] = 1'b1;
    wait_idle(0);
    @(negedge clk);
    chk("bp_ackq", 64'(qsize(0)), 64'h0);

    // Reset while an ack is pending drops it and clears every lock
    @(posedge clk);
    #1 out_tready[1] = 1'b0;
    issue(1, 4'd2, 8'h04, 8'd4);
    @(negedge clk);
    @(negedge clk);
    chk("rs_pending", 64'(out_tvalid[1]), 64'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rs_tvalid", 64'(out_tvalid[1]), 64'h0);
    chk("rs_busy1", 64'(locks_busy[1]), 64'h0);
    chk("rs_busy0", 64'(locks_busy[0]), 64'h0);
    chk("rs_tdata", out_tdata[1], 64'h0);
    @(negedge clk);
    rst = 1'b0;
    out_tready[1] = 1'b1;
    run_vec(100, '{1, 4'd2, 8'h04, 8'd4, 1'b1, 4'd2, 1'b1, 1'b0, 6'h10});
    run_vec(101, '{0, 4'd5, 8'h04, 8'd2, 1'b1, 4'd5, 1'b1, 1'b0, 6'h04});

    chk("final_q0", 64'(q0.size()), 64'h0);
    chk("final_q1", 64'(q1.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
